// File: rtl/ffn_wbi_tile_buffer.sv
// ffn_wbi_tile_buffer: ping-pong tile capture of fetched BRAM words and row-by-row replay to the FFN array
module ffn_wbi_tile_buffer #(
  parameter int DATA_WIDTH = 256,
  parameter int TILE_ROWS  = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  double_buffering,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  out_bank,
  output logic                  overflow,
  output logic [15:0]           tiles_done
);
  localparam int AW = $clog2(TILE_ROWS);
  typedef enum logic [1:0] {EMPTY, FILLING, FULL} bank_st_t;
  bank_st_t st [2];
  bank_st_t st_n [2];
  logic [CNT_WIDTH-1:0] len [2];
  logic [CNT_WIDTH-1:0] len_n [2];
  logic [CNT_WIDTH-1:0] wr_cnt, wr_cnt_n, rd_cnt, rd_cnt_n;
  logic wr_sel, wr_sel_n, rd_sel, rd_sel_n, dbm, live;
  logic idle, chg, m, ws, acc, cls, rd, fin;
  logic [DATA_WIDTH-1:0] mem [2*TILE_ROWS];
  assign in_ready  = live & (st[wr_sel] != FULL);
  assign out_valid = st[rd_sel] == FULL;
  assign out_bank  = rd_sel;
  assign out_last  = out_valid & (rd_cnt == len[rd_sel] - CNT_WIDTH'(1));
  assign out_data  = out_valid ? mem[{rd_sel, rd_cnt[AW-1:0]}] : '0;
  assign idle = (st[0] == EMPTY) & (st[1] == EMPTY) & (wr_cnt == '0);
  assign chg  = idle & (double_buffering != dbm);
  assign m    = idle ? double_buffering : dbm;
  assign ws   = chg ? 1'b0 : wr_sel;
  assign acc  = in_valid & in_ready;
  assign cls  = acc & (in_last | (wr_cnt == CNT_WIDTH'(TILE_ROWS-1)));
  assign rd   = out_valid & out_ready;
  assign fin  = rd & out_last;
  // next bank states, counters and selects; a closing write and a draining read touch different banks
  always_comb begin
    st_n = st;
    len_n = len;
    if (acc) st_n[ws] = cls ? FULL : FILLING;
    if (cls) len_n[ws] = wr_cnt + CNT_WIDTH'(1);
    if (fin) st_n[rd_sel] = EMPTY;
    wr_cnt_n = acc ? (cls ? '0 : wr_cnt + CNT_WIDTH'(1)) : wr_cnt;
    wr_sel_n = (cls & m) ? ~ws : ws;
    rd_cnt_n = rd ? (out_last ? '0 : rd_cnt + CNT_WIDTH'(1)) : rd_cnt;
    rd_sel_n = chg ? 1'b0 : ((fin & dbm) ? ~rd_sel : rd_sel);
  end
  // control state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st <= '{EMPTY, EMPTY};
      len <= '{default: '0};
      wr_cnt <= '0;
      rd_cnt <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      dbm <= 1'b0;
      live <= 1'b0;
      overflow <= 1'b0;
      tiles_done <= '0;
    end else begin
      st <= st_n;
      len <= len_n;
      wr_cnt <= wr_cnt_n;
      rd_cnt <= rd_cnt_n;
      wr_sel <= wr_sel_n;
      rd_sel <= rd_sel_n;
      dbm <= m;
      live <= 1'b1;
      overflow <= overflow | (in_valid & ~in_ready);
      tiles_done <= tiles_done + {15'b0, fin};
    end
  end
  // tile storage, contents are meaningless until written
  always_ff @(posedge clk) begin
    if (acc) mem[{ws, wr_cnt[AW-1:0]}] <= in_data;
  end
endmodule

// File: tb/tb_ffn_wbi_tile_buffer.sv
// tb_ffn_wbi_tile_buffer: directed self-checking bench for the tile buffer with TILE_ROWS=4
module tb_ffn_wbi_tile_buffer;
  localparam int DW = 256;
  logic clk = 0, rst = 1, double_buffering = 1, in_valid = 0, in_last = 0, out_ready = 0;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, out_last, out_bank, overflow;
  logic [DW-1:0] out_data;
  logic [15:0] tiles_done;
  int checks = 0, failures = 0;
  ffn_wbi_tile_buffer #(.DATA_WIDTH(DW), .TILE_ROWS(4), .CNT_WIDTH(3)) dut (
    .clk(clk), .rst(rst), .double_buffering(double_buffering),
    .in_valid(in_valid), .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .out_bank(out_bank), .overflow(overflow), .tiles_done(tiles_done)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string t, input logic [DW-1:0] o, input logic [DW-1:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", t, o, e);
    end
  endtask
  task automatic wr(input int d, input logic l);
    in_valid = 1;
    in_data = DW'(d);
    in_last = l;
  endtask
  task automatic row(input string t, input int d, input logic b, input logic l);
    chk({t, "_valid"}, DW'(out_valid), DW'(1));
    chk({t, "_data"}, out_data, DW'(d));
    chk({t, "_bank"}, DW'(out_bank), DW'(b));
    chk({t, "_last"}, DW'(out_last), DW'(l));
  endtask
  initial begin
    #1;
    chk("rst_in_ready", DW'(in_ready), DW'(0));
    chk("rst_out_valid", DW'(out_valid), DW'(0));
    chk("rst_out_data", out_data, DW'(0));
    chk("rst_overflow", DW'(overflow), DW'(0));
    chk("rst_tiles", DW'(tiles_done), DW'(0));
    step(); step(); step();
    rst = 0;
    chk("rel_in_ready0", DW'(in_ready), DW'(0));
    step();
    chk("rel_in_ready1", DW'(in_ready), DW'(1));
    chk("rel_out_valid", DW'(out_valid), DW'(0));
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      wr(32'h1000 + i, 0);
      chk("full_in_ready", DW'(in_ready), DW'(1));
      chk("full_no_valid", DW'(out_valid), DW'(0));
      step();
    end
    in_valid = 0;
    for (int j = 0; j < 4; j++) begin
      row("full", 32'h1000 + j, 0, j == 3);
      step();
    end
    chk("full_tiles", DW'(tiles_done), DW'(1));
    chk("full_idle", DW'(out_valid), DW'(0));
    double_buffering = 0;
    step();
    double_buffering = 1;
    step();
    chk("mode_bank0", DW'(out_bank), DW'(0));
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      wr(32'h1000 + i, 0);
      chk("bp_in_ready", DW'(in_ready), DW'(1));
      step();
    end
    in_valid = 0;
    chk("bp_word9_stall", DW'(in_ready), DW'(0));
    chk("bp_overflow", DW'(overflow), DW'(0));
    out_ready = 1;
    for (int j = 0; j < 4; j++) begin
      row("bp_b0", 32'h1000 + j, 0, j == 3);
      chk("bp_b0_stall", DW'(in_ready), DW'(0));
      step();
    end
    chk("bp_ready_back", DW'(in_ready), DW'(1));
    for (int j = 0; j < 4; j++) begin
      row("bp_b1", 32'h1004 + j, 1, j == 3);
      if (j < 2) wr(32'h1008 + j, 0);
      else in_valid = 0;
      chk("bp_b1_ready", DW'(in_ready), DW'(1));
      step();
    end
    in_valid = 0;
    chk("bp_fill_novalid", DW'(out_valid), DW'(0));
    wr(32'h100A, 1);
    step();
    in_valid = 0;
    in_last = 0;
    for (int j = 0; j < 3; j++) begin
      row("bp_rest", 32'h1008 + j, 0, j == 2);
      step();
    end
    chk("bp_tiles", DW'(tiles_done), DW'(4));
    double_buffering = 0;
    step();
    double_buffering = 1;
    step();
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin
      wr(32'h2000 + i, i == 5);
      step();
    end
    in_valid = 0;
    in_last = 0;
    chk("part_stall", DW'(in_ready), DW'(0));
    out_ready = 1;
    for (int j = 0; j < 6; j++) begin
      row("part", 32'h2000 + j, j >= 4, (j == 3) || (j == 5));
      step();
    end
    chk("part_tiles", DW'(tiles_done), DW'(6));
    double_buffering = 0;
    step();
    for (int t = 0; t < 2; t++) begin
      for (int i = 0; i < 4; i++) begin
        wr(32'h3000 + 4 * t + i, 0);
        chk("sb_in_ready", DW'(in_ready), DW'(1));
        step();
      end
      in_valid = 0;
      for (int j = 0; j < 4; j++) begin
        row("sb", 32'h3000 + 4 * t + j, 0, j == 3);
        chk("sb_stall", DW'(in_ready), DW'(0));
        step();
      end
      chk("sb_ready_back", DW'(in_ready), DW'(1));
    end
    chk("sb_tiles", DW'(tiles_done), DW'(8));
    double_buffering = 1;
    step();
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      wr(32'h4000 + i, 0);
      step();
    end
    in_valid = 0;
    chk("ov_stall", DW'(in_ready), DW'(0));
    chk("ov_clear", DW'(overflow), DW'(0));
    wr(32'hDEAD, 0);
    step();
    in_valid = 0;
    chk("ov_set", DW'(overflow), DW'(1));
    step(); step();
    chk("ov_sticky", DW'(overflow), DW'(1));
    out_ready = 1;
    step(); step();
    row("ov_drain", 32'h4002, 0, 0);
    chk("ov_tiles", DW'(tiles_done), DW'(8));
    rst = 1;
    #1;
    chk("mr_out_valid", DW'(out_valid), DW'(0));
    chk("mr_overflow", DW'(overflow), DW'(0));
    chk("mr_tiles", DW'(tiles_done), DW'(0));
    chk("mr_in_ready", DW'(in_ready), DW'(0));
    chk("mr_out_data", out_data, DW'(0));
    chk("mr_out_bank", DW'(out_bank), DW'(0));
    step();
    rst = 0;
    chk("mr_rel0", DW'(in_ready), DW'(0));
    step();
    chk("mr_rel1", DW'(in_ready), DW'(1));
    chk("mr_no_tile", DW'(out_valid), DW'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ffn_wbi_tile_buffer.md
Name: ffn_wbi_tile_buffer

Overview:
- Sits directly downstream of the FFN weight/bias/input BRAM fetch unit.
- Captures the 256-bit words the fetch unit streams out of BRAM (doutb) into a ping-pong pair of tile banks.
- Replays each completed tile, row by row, to the FFN compute array over a valid/ready stream.
- Throttles the fetch side when no bank is free; supports single-bank operation when double buffering is off.

Parameters:
DATA_WIDTH, 256, width of one fetched BRAM word / one tile row
TILE_ROWS, 32, rows per full tile (power of two, >=2)
CNT_WIDTH, 6, width of row counters; must hold TILE_ROWS (log2(TILE_ROWS)+1)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  asynchronous, active-high reset
double_buffering  in  1  1 = ping-pong over banks 0/1; 0 = bank 0 only
in_valid  in  1  fetch word present on in_data this cycle
in_data  in  DATA_WIDTH  fetched BRAM word
in_last  in  1  final word of the fetch (qualified by in_valid); closes a partial tile
in_ready  out  1  buffer can accept a word this cycle
out_valid  out  1  out_data holds a valid tile row
out_ready  in  1  compute array accepts the row
out_data  out  DATA_WIDTH  current tile row
out_last  out  1  current row is the last row of its tile
out_bank  out  1  bank index being read
overflow  out  1  sticky: word offered while in_ready=0
tiles_done  out  16  count of tiles fully drained, wraps at 65535->0

Behaviour:
- Reset (async, rst=1): both banks empty, wr_sel=0, rd_sel=0, wr_cnt=0, rd_cnt=0. Outputs: in_ready=0 while rst=1, then 1 on the first clock after release; out_valid=0, out_last=0, out_bank=0, overflow=0, tiles_done=0, out_data=0. Bank contents are don't-care.
- Per-bank state: EMPTY / FILLING / FULL, plus len[CNT_WIDTH-1:0].
- Write side: in_ready = (state[wr_sel] != FULL). An accepted word (in_valid & in_ready) goes to bank[wr_sel][wr_cnt] and wr_cnt increments.
  - Tile close: the tile closes when wr_cnt reaches TILE_ROWS-1, or when in_last is accepted.
  - On close: len = wr_cnt+1, state = FULL, wr_cnt = 0, and wr_sel toggles only if double_buffering=1.
- Overflow: in_valid & ~in_ready drops the word and sets overflow; overflow clears only on rst.
- Read side: out_valid = (state[rd_sel] == FULL), registered, so it asserts the cycle after the tile closes.
  - out_data = bank[rd_sel][rd_cnt]; out_last = (rd_cnt == len-1); out_bank = rd_sel.
  - On out_valid & out_ready, rd_cnt increments. On the out_last handshake: state = EMPTY, rd_cnt = 0, tiles_done+1, and rd_sel toggles only if double_buffering=1.
  - out_data holds stable while out_valid & ~out_ready.
- Latency: the first row is available 1 cycle after the closing write. With both sides streaming, sustained throughput is 1 word/cycle.
- Single-bank mode: writes stall (in_ready=0) from tile close until the read-side out_last handshake. in_ready returns to 1 the cycle after that handshake.
- Simultaneous events: a write closing bank X and a drain freeing bank Y in the same cycle both take effect. A write into a bank being freed in that cycle is not possible, because a FULL bank blocks writes.
- Mode change: double_buffering is sampled only when both banks are EMPTY and wr_cnt=0. Otherwise the previous mode persists. On a change, wr_sel and rd_sel are forced to 0.
- in_last on a word that also reaches TILE_ROWS: single close, len=TILE_ROWS.
- Reset mid-operation discards all buffered data. No partial tile is emitted.

Test Plan:
- Test parameters: TILE_ROWS=4, double_buffering=1.
- Reset/idle: hold rst 3 cycles, release -> out_valid=0, overflow=0, tiles_done=0; in_ready=1 from the first post-reset edge.
- Full tile: stream 0x1000..0x1003 with out_ready=1 -> bank0 rows out 0x1000..0x1003 starting 1 cycle after the 4th write; out_last on 0x1003; tiles_done=1.
- Ping-pong backpressure: out_ready=0, stream 0x1000..0x1009 -> 8 words accepted, in_ready=0 from word 9 onward. Set out_ready=1 -> bank0 drains, then bank1. in_ready returns the cycle after bank0's out_last; remaining words are accepted into bank0.
- Partial tile: 6 words with in_last on word 6 -> tile A len 4, tile B len 2; out_last on the 2nd row of bank1; tiles_done=2.
- Single-bank mode (double_buffering=0): 8 words, out_ready=1 -> in_ready low for the whole drain of tile 1; out_bank always 0; tiles_done=2.
- Overflow and mid-op reset: force in_valid while in_ready=0 -> overflow=1 and stays set. Assert rst mid-drain -> out_valid drops immediately, overflow=0, tiles_done=0.
